mem_port_arbiter: RTL

- Shares one request/response memory port between the hart's instruction-fetch side and data side.
- Replaces the combinational imem/dmem model: the hart stalls on ready/valid until its access completes.
- One transaction outstanding at a time; round-robin grant when both sides request; watchdog timeout returns an error response.

---
 rtl/mem_port_arbiter.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// mem_port_arbiter : round-robin share of one memory port between fetch and
//                    data, one transaction in flight, watchdog error response
// Revision 1.0 : initial release
// ============================================================================
module mem_port_arbiter #(
  parameter int TIMEOUT = 256,
  parameter int CNT_W   = 9
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_if_req,
  input  logic [31:0] i_if_addr,
  output logic        o_if_ready,
  output logic        o_if_valid,
  output logic [31:0] o_if_rdata,
  output logic        o_if_err,
  input  logic        i_d_req,
  input  logic [31:0] i_d_addr,
  input  logic        i_d_wen,
  input  logic [31:0] i_d_wdata,
  input  logic [3:0]  i_d_mask,
  output logic        o_d_ready,
  output logic        o_d_valid,
  output logic [31:0] o_d_rdata,
  output logic        o_d_err,
  output logic        o_mem_req,
  output logic [31:0] o_mem_addr,
  output logic        o_mem_wen,
  output logic [31:0] o_mem_wdata,
  output logic [3:0]  o_mem_mask,
  input  logic        i_mem_ready,
  input  logic        i_mem_valid,
  input  logic [31:0] i_mem_rdata
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  localparam logic             c_WDOG_EN  = (TIMEOUT != 0);
  localparam logic [CNT_W-1:0] c_CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_t            state_q, state_d;
  logic              last_d_q, last_d_d;    // 1: most recent grant went to data
  logic              owner_d_q, owner_d_d;  // 1: data side owns the transaction
  logic [31:0]       addr_q, addr_d;
  logic              wen_q, wen_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [3:0]        mask_q, mask_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              err_q, err_d;
  logic [31:0]       if_rdata_q, if_rdata_d;
  logic [31:0]       d_rdata_q, d_rdata_d;

  logic              grant_d;
  logic              grant_if;
  logic              timeout_hit;

  always_comb begin
    grant_d     = (state_q == ST_IDLE) && i_d_req && (!i_if_req || !last_d_q);
    grant_if    = (state_q == ST_IDLE) && i_if_req && !grant_d;
    // cnt_q counts completed ISSUE/WAIT cycles, so this is the TIMEOUT-th one
    timeout_hit = c_WDOG_EN && (cnt_q == c_CNT_LAST);
  end

  always_comb begin
    state_d    = state_q;
    last_d_d   = last_d_q;
    owner_d_d  = owner_d_q;
    addr_d     = addr_q;
    wen_d      = wen_q;
    wdata_d    = wdata_q;
    mask_d     = mask_q;
    cnt_d      = cnt_q;
    err_d      = err_q;
    if_rdata_d = if_rdata_q;
    d_rdata_d  = d_rdata_q;

    case (state_q)
      ST_IDLE: begin
        if (grant_d) begin
          addr_d    = i_d_addr;
          wen_d     = i_d_wen;
          wdata_d   = i_d_wdata;
          mask_d    = i_d_mask;
          owner_d_d = 1'b1;
          last_d_d  = 1'b1;
          cnt_d     = '0;
          state_d   = ST_ISSUE;
        end else if (grant_if) begin
          addr_d    = i_if_addr;
          wen_d     = 1'b0;
          wdata_d   = 32'd0;
          mask_d    = 4'b1111;
          owner_d_d = 1'b0;
          last_d_d  = 1'b0;
          cnt_d     = '0;
          state_d   = ST_ISSUE;
        end
      end

      ST_ISSUE: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (timeout_hit) begin
          err_d   = 1'b1;
          state_d = ST_RESP;
          if (owner_d_q) d_rdata_d  = 32'd0;
          else           if_rdata_d = 32'd0;
        end else if (i_mem_ready) begin
          state_d = ST_WAIT;
        end
      end

      ST_WAIT: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (i_mem_valid) begin
          err_d   = 1'b0;
          state_d = ST_RESP;
          if (owner_d_q) d_rdata_d  = wen_q ? 32'd0 : i_mem_rdata;
          else           if_rdata_d = i_mem_rdata;
        end else if (timeout_hit) begin
          err_d   = 1'b1;
          state_d = ST_RESP;
          if (owner_d_q) d_rdata_d  = 32'd0;
          else           if_rdata_d = 32'd0;
        end
      end

      ST_RESP: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= ST_IDLE;
      last_d_q   <= 1'b0;
      owner_d_q  <= 1'b0;
      addr_q     <= 32'd0;
      wen_q      <= 1'b0;
      wdata_q    <= 32'd0;
      mask_q     <= 4'd0;
      cnt_q      <= '0;
      err_q      <= 1'b0;
      if_rdata_q <= 32'd0;
      d_rdata_q  <= 32'd0;
    end else begin
      state_q    <= state_d;
      last_d_q   <= last_d_d;
      owner_d_q  <= owner_d_d;
      addr_q     <= addr_d;
      wen_q      <= wen_d;
      wdata_q    <= wdata_d;
      mask_q     <= mask_d;
      cnt_q      <= cnt_d;
      err_q      <= err_d;
      if_rdata_q <= if_rdata_d;
      d_rdata_q  <= d_rdata_d;
    end
  end

  always_comb begin
    o_if_ready  = grant_if;
    o_d_ready   = grant_d;
    o_mem_req   = (state_q == ST_ISSUE);
    o_mem_addr  = addr_q;
    o_mem_wen   = wen_q;
    o_mem_wdata = wdata_q;
    o_mem_mask  = mask_q;
    o_if_valid  = (state_q == ST_RESP) && !owner_d_q;
    o_d_valid   = (state_q == ST_RESP) && owner_d_q;
    o_if_err    = o_if_valid && err_q;
    o_d_err     = o_d_valid && err_q;
    o_if_rdata  = if_rdata_q;
    o_d_rdata   = d_rdata_q;
  end

endmodule
`default_nettype wire
